fetch_queue: RTL and testbench

Instruction fetch stage placed directly upstream of the single-cycle datapath's decode/execute logic. Owns the program counter and issues word requests to an instruction memory with variable latency (valid/ready request channel, in-order response channel). Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready handshake. A taken-branch redirect flushes the queue and squashes in-flight responses.

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_queue.sv | 141 ++++++++++++++
 tb/tb_fetch_queue.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default widths, reset PC,
// FSM state encoding and the canonical NOP word.
package fetch_queue_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam logic [63:0] RESET_PC_DEF = 64'd0;
  localparam logic [31:0] NOP          = 32'h0000_0013;

  // DRAIN while responses to squashed requests are still inbound
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory channel: valid/ready request, in-order response without backpressure.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) ();

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Registered DEPTH x W FIFO with occupancy count, synchronous clear and
// simultaneous push/pop. DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 96
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Storage is reset too so the head reads zero straight out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues credit-limited word requests, queues returned
// instructions for decode and squashes in-flight responses on redirect.
// Optional build macro FETCH_PERF_EN adds delivered/redirect performance counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic             clk,
  input  logic             pc_reset,
  fetch_queue_if.master    imem,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst,
  output logic [XLEN-1:0]  inst_pc,
  output logic [XLEN-1:0]  inst_pc_plus_4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_fetched,
  output logic [31:0]      perf_flushes
`endif
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned EW = 32 + XLEN;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

  fq_state_e       state, state_n;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n;
  logic [XLEN-1:0] resp_pc, resp_pc_n;
  logic [CW-1:0]   outstanding, outstanding_n;
  logic [CW-1:0]   discard, discard_n;
  logic [CW-1:0]   count;
  logic            req_valid_c;
  logic            req_fire;
  logic            push;
  logic            pop;
  logic [EW-1:0]   head;

  // State register
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      state       <= RUN;
      fetch_pc    <= PC_RST;
      resp_pc     <= PC_RST;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

  // Next state: redirect wins over request, response and pop in its cycle
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    resp_pc_n     = resp_pc;
    outstanding_n = outstanding;
    discard_n     = discard;
    push          = 1'b0;
    pop           = 1'b0;

    req_valid_c = !pc_reset && !redirect_valid &&
                  ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
    req_fire    = req_valid_c && imem.imem_req_ready;

    if (redirect_valid) begin
      fetch_pc_n    = redirect_pc & ALIGN_MASK;
      resp_pc_n     = redirect_pc & ALIGN_MASK;
      outstanding_n = outstanding - CW'(imem.imem_resp_valid);
      discard_n     = outstanding - CW'(imem.imem_resp_valid);
    end else begin
      pop = inst_valid && inst_ready;
      if (req_fire) begin
        fetch_pc_n = fetch_pc + XLEN'(4);
      end
      if (imem.imem_resp_valid) begin
        case (state)
          RUN: begin
            push      = 1'b1;
            resp_pc_n = resp_pc + XLEN'(4);
          end
          DRAIN:   discard_n = discard - CW'(1);
          default: ;
        endcase
      end
      outstanding_n = outstanding + CW'(req_fire) - CW'(imem.imem_resp_valid);
    end

    state_n = (discard_n != '0) ? DRAIN : RUN;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (pc_reset),
    .clear     (redirect_valid),
    .push      (push),
    .push_data ({resp_pc, imem.imem_resp_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

  assign imem.imem_req_valid = req_valid_c;
  assign imem.imem_req_addr  = fetch_pc;
  assign inst_valid          = (count != '0);
  assign inst                = head[31:0];
  assign inst_pc             = head[EW-1:32];
  assign inst_pc_plus_4      = head[EW-1:32] + XLEN'(4);

`ifdef FETCH_PERF_EN
  // Wrapping event counters
  always_ff @(posedge clk) begin
    if (pc_reset) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushes <= perf_flushes + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a latency-configurable memory model plus an
// epoch-based reference of which instructions decode must see, in what order.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          epoch;
  } req_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] data;
  } ent_t;

  logic            clk = 1'b0;
  logic            pc_reset;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] inst_pc_plus_4;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_flushes;
`endif

  fetch_queue_if #(.XLEN(XLEN)) mem_if ();

  fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (64'd0)
  ) dut (
    .clk            (clk),
    .pc_reset       (pc_reset),
    .imem           (mem_if.master),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_pc_plus_4 (inst_pc_plus_4)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  // Reference model state
  req_t        inflight[$];
  ent_t        exp_q[$];
  logic [63:0] exp_fetch;
  int          epoch;
  logic [31:0] exp_fetched;
  logic [31:0] exp_flushes;

  // Logs of observed DUT events for directed checks
  logic [63:0] fire_addrs[$];
  logic [63:0] pop_pcs[$];
  logic [63:0] pop_p4[$];
  int          pop_cycs[$];
  int          first_fire_cyc;
  int          first_valid_cyc;
  logic        last_req_valid;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return NOP ^ (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic clear_logs();
    fire_addrs.delete();
    pop_pcs.delete();
    pop_p4.delete();
    pop_cycs.delete();
    first_fire_cyc  = -1;
    first_valid_cyc = -1;
  endtask

  // Hold pc_reset for n cycles; memory shares the reset so nothing stays in flight
  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pc_reset               = 1'b1;
      redirect_valid         = 1'b0;
      redirect_pc            = '0;
      inst_ready             = 1'b0;
      mem_if.imem_req_ready  = 1'b1;
      mem_if.imem_resp_valid = 1'b0;
      mem_if.imem_resp_data  = $urandom;
      #1;
      check_eq("rst_req_valid", 64'(mem_if.imem_req_valid), 64'd0);
      if (i > 0) begin
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        check_eq("rst_inst", 64'(inst), 64'd0);
        check_eq("rst_inst_pc", inst_pc, 64'd0);
`ifdef FETCH_PERF_EN
        check_eq("rst_perf_fetched", 64'(perf_fetched), 64'd0);
        check_eq("rst_perf_flushes", 64'(perf_flushes), 64'd0);
`endif
      end
      cyc++;
    end
    inflight.delete();
    exp_q.delete();
    exp_fetch   = 64'd0;
    epoch       = 0;
    exp_fetched = '0;
    exp_flushes = '0;
    clear_logs();
  endtask

  // One clock cycle: drive, check against the model, then advance the model
  task automatic step(input bit redir, input logic [63:0] tgt, input bit rdy, input bit mrdy);
    int   n_out;
    bit   have_resp;
    bit   exp_rv;
    req_t r;
    ent_t e;
    @(negedge clk);
    pc_reset              = 1'b0;
    redirect_valid        = redir;
    redirect_pc           = tgt;
    inst_ready            = rdy;
    mem_if.imem_req_ready = mrdy;
    n_out     = inflight.size();
    have_resp = (n_out > 0) && (inflight[0].due <= cyc);
    if (have_resp) begin
      r = inflight.pop_front();
      mem_if.imem_resp_valid = 1'b1;
      mem_if.imem_resp_data  = mem_word(r.addr);
    end else begin
      mem_if.imem_resp_valid = 1'b0;
      mem_if.imem_resp_data  = $urandom;
    end
    #1;

    exp_rv = !redir && ((exp_q.size() + n_out) < DEPTH);
    check_eq("req_valid", 64'(mem_if.imem_req_valid), 64'(exp_rv));
    if (exp_rv) check_eq("req_addr", mem_if.imem_req_addr, exp_fetch);
    check_eq("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      check_eq("inst", 64'(inst), 64'(exp_q[0].data));
      check_eq("inst_pc", inst_pc, exp_q[0].pc);
      check_eq("inst_pc_plus_4", inst_pc_plus_4, exp_q[0].pc + 64'd4);
    end
`ifdef FETCH_PERF_EN
    check_eq("perf_fetched", 64'(perf_fetched), 64'(exp_fetched));
    check_eq("perf_flushes", 64'(perf_flushes), 64'(exp_flushes));
`endif

    last_req_valid = mem_if.imem_req_valid;
    if (mem_if.imem_req_valid && mrdy) begin
      fire_addrs.push_back(mem_if.imem_req_addr);
      if (first_fire_cyc < 0) first_fire_cyc = cyc;
    end
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (inst_valid && rdy && !redir) begin
      pop_pcs.push_back(inst_pc);
      pop_p4.push_back(inst_pc_plus_4);
      pop_cycs.push_back(cyc);
    end

    if (redir) begin
      epoch++;
      exp_q.delete();
      exp_fetch = tgt & ~64'd3;
      exp_flushes++;
      clear_logs();
    end else begin
      if (exp_q.size() != 0 && rdy) begin
        void'(exp_q.pop_front());
        exp_fetched++;
      end
      if (have_resp && r.epoch == epoch) begin
        e.pc   = r.addr;
        e.data = mem_word(r.addr);
        exp_q.push_back(e);
      end
      if (exp_rv && mrdy) begin
        r.addr  = exp_fetch;
        r.due   = cyc + lat;
        r.epoch = epoch;
        inflight.push_back(r);
        exp_fetch = exp_fetch + 64'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    pc_reset               = 1'b1;
    redirect_valid         = 1'b0;
    redirect_pc            = '0;
    inst_ready             = 1'b0;
    mem_if.imem_req_ready  = 1'b0;
    mem_if.imem_resp_valid = 1'b0;
    mem_if.imem_resp_data  = '0;
    last_req_valid         = 1'b0;

    // Streaming at latency 1 with decode always ready
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 1);
    check_eq("A_first_valid_delay", 64'(first_valid_cyc - first_fire_cyc), 64'd2);
    check_eq("A_pop_count_ge4", 64'(pop_pcs.size() >= 4), 64'd1);
    if (pop_pcs.size() >= 4) begin
      check_eq("A_pop0", pop_pcs[0], 64'd0);
      check_eq("A_pop1", pop_pcs[1], 64'd4);
      check_eq("A_pop2", pop_pcs[2], 64'd8);
      check_eq("A_pop3", pop_pcs[3], 64'd12);
      check_eq("A_consecutive", 64'(pop_cycs[3] - pop_cycs[0]), 64'd3);
    end

    // Decode stalled: credits cap requests at DEPTH
    do_reset(2);
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1);
    check_eq("B_fires", 64'(fire_addrs.size()), 64'd4);
    check_eq("B_req_valid_stalled", 64'(last_req_valid), 64'd0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 1);
    check_eq("B_resume_seen", 64'(fire_addrs.size() > 4), 64'd1);
    if (fire_addrs.size() > 4) check_eq("B_resume_addr", fire_addrs[4], 64'd16);

    // Latency 3, redirect with three requests in flight
    lat = 3;
    do_reset(2);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 1);
    check_eq("C_outstanding", 64'(inflight.size()), 64'd3);
    step(1, 64'h100, 1, 1);
    for (int i = 0; i < 12; i++) step(0, '0, 1, 1);
    check_eq("C_pops_seen", 64'(pop_pcs.size() >= 2), 64'd1);
    if (pop_pcs.size() >= 2) begin
      check_eq("C_first_pc", pop_pcs[0], 64'h100);
      check_eq("C_second_pc", pop_pcs[1], 64'h104);
    end

    // Redirect coinciding with a response and a pop
    lat = 1;
    do_reset(2);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 1);
    step(1, 64'h100, 1, 1);
    step(0, '0, 1, 1);
    check_eq("D_fire_seen", 64'(fire_addrs.size()), 64'd1);
    if (fire_addrs.size() >= 1) check_eq("D_fire_addr", fire_addrs[0], 64'h100);
    check_eq("D_empty_pops", 64'(pop_pcs.size()), 64'd0);

    // Redirect to the top of the address space: wrap to zero
    step(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 1);
    for (int i = 0; i < 6; i++) step(0, '0, 1, 1);
    check_eq("E_fires_seen", 64'(fire_addrs.size() >= 2), 64'd1);
    if (fire_addrs.size() >= 2) begin
      check_eq("E_fire0", fire_addrs[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("E_fire1", fire_addrs[1], 64'd0);
    end
    check_eq("E_pops_seen", 64'(pop_pcs.size() >= 2), 64'd1);
    if (pop_pcs.size() >= 2) begin
      check_eq("E_pop0_pc", pop_pcs[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check_eq("E_pop0_p4", pop_p4[0], 64'd0);
      check_eq("E_pop1_pc", pop_pcs[1], 64'd0);
    end

    // Counter scenario: 10 delivered, 2 redirects, then mid-stream reset
    do_reset(2);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 1);
    step(1, 64'h200, 0, 1);
    for (int i = 0; i < 5; i++) step(0, '0, 1, 1);
    step(1, 64'h300, 0, 1);
    for (int i = 0; i < 12; i++) begin
      step(0, '0, exp_fetched < 32'd10, 1);
    end
    check_eq("F_model_fetched", 64'(exp_fetched), 64'd10);
`ifdef FETCH_PERF_EN
    check_eq("F_perf_fetched", 64'(perf_fetched), 64'd10);
    check_eq("F_perf_flushes", 64'(perf_flushes), 64'd2);
`endif
    do_reset(2);

    // Randomized traffic
    begin
      int rdy_pct = 70;
      int mrdy_pct = 80;
      for (int i = 0; i < 4000; i++) begin
        if (i % 250 == 0) begin
          lat      = int'($urandom_range(1, 6));
          rdy_pct  = int'($urandom_range(20, 100));
          mrdy_pct = int'($urandom_range(30, 100));
        end
        if ($urandom_range(0, 999) < 3) begin
          do_reset(1 + int'($urandom_range(0, 1)));
        end else begin
          step($urandom_range(0, 99) < 5,
               {$urandom, $urandom},
               $urandom_range(0, 99) < rdy_pct,
               $urandom_range(0, 99) < mrdy_pct);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
